// File: rtl/demux_stream_nway_pkg.sv
// Shared constants for the N-way stream demultiplexer: drop counter sizing,
// slot state encodings and the saturating increment used by the drop counter.
package demux_stream_nway_pkg;

   localparam int          DEMUX_CNT_W   = 16;
   localparam logic [15:0] DEMUX_CNT_MAX = 16'hFFFF;

   localparam logic SLOT_EMPTY = 1'b0;
   localparam logic SLOT_FULL  = 1'b1;

   function automatic logic [DEMUX_CNT_W-1:0] sat_inc(input logic [DEMUX_CNT_W-1:0] v);
      return (v == DEMUX_CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: holds a single word from load until the consumer
// drains it; a load in the same cycle as a drain refills it (pass-through).
module demux_slot
   import demux_stream_nway_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             load,
   input  logic             drain,
   input  logic [WIDTH-1:0] load_data,
   output logic             valid,
   output logic [WIDTH-1:0] data
);

   logic             state_p1;
   logic [WIDTH-1:0] data_p1;

   // Load wins over drain so a simultaneous drain+load keeps the slot full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p1 <= SLOT_EMPTY;
         data_p1  <= '0;
      end else if (flush) begin
         state_p1 <= SLOT_EMPTY;
         data_p1  <= '0;
      end else if (load) begin
         state_p1 <= SLOT_FULL;
         data_p1  <= load_data;
      end else if (drain) begin
         state_p1 <= SLOT_EMPTY;
      end
   end

   assign valid = (state_p1 == SLOT_FULL);
   assign data  = data_p1;

endmodule

// File: rtl/demux_stream_nway.sv
// Registered N-way valid/ready demultiplexer with per-channel backpressure.
// Optional drop counter enabled by defining DEMUX_STREAM_DROP_CNT_EN.
module demux_stream_nway
   import demux_stream_nway_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NOUT  = 8,
   parameter int SEL_W = $clog2(NOUT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic [WIDTH-1:0]       in_data,
   output logic [NOUT-1:0]        out_valid,
   input  logic [NOUT-1:0]        out_ready,
   output logic [NOUT*WIDTH-1:0]  out_data,
   output logic                   sel_err,
   output logic [DEMUX_CNT_W-1:0] drop_cnt
);

   localparam int NPAD = 1 << SEL_W;

   logic            in_range;
   logic            accept;
   logic [NOUT-1:0] load_vec;
   logic [NPAD-1:0] valid_pad;
   logic [NPAD-1:0] ready_pad;

   // Pad to a power of two so any in_sel value indexes safely.
   assign valid_pad = NPAD'(out_valid);
   assign ready_pad = NPAD'(out_ready);
   assign in_range  = ({1'b0, in_sel} < (SEL_W+1)'(NOUT));
   assign in_ready  = rst_n & ~flush & (~in_range | ~valid_pad[in_sel] | ready_pad[in_sel]);
   assign accept    = in_valid & in_ready;

   for (genvar i = 0; i < NOUT; i++) begin : g_slot
      assign load_vec[i] = accept & in_range & (in_sel == SEL_W'(i));

      demux_slot #(.WIDTH(WIDTH)) u_slot (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush),
         .load      (load_vec[i]),
         .drain     (out_ready[i]),
         .load_data (in_data),
         .valid     (out_valid[i]),
         .data      (out_data[i*WIDTH +: WIDTH])
      );
   end

   // Out-of-range words are consumed and reported one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sel_err <= 1'b0;
      else        sel_err <= accept & ~in_range;
   end

`ifdef DEMUX_STREAM_DROP_CNT_EN
   logic [DEMUX_CNT_W-1:0] drop_cnt_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  drop_cnt_p1 <= '0;
      else if (accept & ~in_range) drop_cnt_p1 <= sat_inc(drop_cnt_p1);
   end

   assign drop_cnt = drop_cnt_p1;
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_stream_nway.sv
// Scoreboard bench for demux_stream_nway (WIDTH=16, NOUT=6).
module tb_demux_stream_nway;

   localparam int WIDTH = 16;
   localparam int NOUT  = 6;
   localparam int SEL_W = 3;
`ifdef DEMUX_STREAM_DROP_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [SEL_W-1:0]      in_sel;
   logic [WIDTH-1:0]      in_data;
   logic [NOUT-1:0]       out_valid;
   logic [NOUT-1:0]       out_ready;
   logic [NOUT*WIDTH-1:0] out_data;
   logic                  sel_err;
   logic [15:0]           drop_cnt;

   int n_checks = 0;
   int n_fails  = 0;

   logic [WIDTH-1:0] exp_q [NOUT][$];

   demux_stream_nway #(.WIDTH(WIDTH), .NOUT(NOUT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sel_err   (sel_err),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every output handshake pops its channel's expected word.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int i = 0; i < NOUT; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  chk($sformatf("unexpected_ch%0d", i), 32'(out_data[i*WIDTH +: WIDTH]), 32'hDEAD_BEEF);
               end else begin
                  chk($sformatf("data_ch%0d", i), 32'(out_data[i*WIDTH +: WIDTH]), 32'(exp_q[i].pop_front()));
               end
            end
         end
      end
   end

   task automatic clear_queues();
      for (int i = 0; i < NOUT; i++) exp_q[i].delete();
   endtask

   // Present one word and hold it until accepted; called at posedge+1, returns at posedge+1.
   task automatic send(input int sel, input logic [WIDTH-1:0] d);
      bit done = 1'b0;
      in_valid = 1'b1;
      in_sel   = SEL_W'(sel);
      in_data  = d;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            if (sel < NOUT) exp_q[sel].push_back(d);
            done = 1'b1;
         end
      end
      if (!done) chk("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      logic [NOUT-1:0] ov_snap;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = '0;
      in_data   = '0;
      out_ready = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sel_err", 32'(sel_err), 32'd0);
      chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Routing to every channel
      out_ready = '1;
      for (int k = 0; k < NOUT; k++) begin
         send(k, 16'hA5A0 + 16'(k));
         chk($sformatf("route_vld%0d", k), 32'(out_valid[k]), 32'd1);
         chk($sformatf("route_dat%0d", k), 32'(out_data[k*WIDTH +: WIDTH]), 32'(16'hA5A0 + 16'(k)));
      end
      @(posedge clk); #1;

      // Backpressure on channel 2
      out_ready = 6'b111011;
      send(2, 16'h1111);
      in_valid = 1'b1;
      in_sel   = 3'd2;
      in_data  = 16'h2222;
      #1 chk("bp_ready_sel2", 32'(in_ready), 32'd0);
      in_sel = 3'd3;
      #1 chk("bp_ready_sel3", 32'(in_ready), 32'd1);
      in_sel = 3'd2;
      #1 chk("bp_hold_data", 32'(out_data[2*WIDTH +: WIDTH]), 32'h1111);
      out_ready = '1;
      #1 chk("bp_ready_released", 32'(in_ready), 32'd1);
      exp_q[2].push_back(16'h2222);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_pass_vld", 32'(out_valid[2]), 32'd1);
      chk("bp_pass_dat", 32'(out_data[2*WIDTH +: WIDTH]), 32'h2222);
      @(posedge clk); #1;

      // Out-of-range select
      ov_snap = out_valid;
      for (int k = 0; k < 3; k++) begin
         send(7, 16'hBAD0 + 16'(k));
         chk("oor_sel_err", 32'(sel_err), 32'd1);
         chk("oor_out_valid", 32'(out_valid), 32'(ov_snap));
      end
      @(posedge clk); #1;
      chk("oor_sel_err_low", 32'(sel_err), 32'd0);
      chk("oor_drop_cnt", 32'(drop_cnt), CNT_EN ? 32'd3 : 32'd0);

      // Flush with pending input
      out_ready = 6'b101110;
      send(0, 16'h0A0A);
      send(4, 16'h4B4B);
      chk("flush_pre_valid", 32'(out_valid), 32'h11);
      in_valid = 1'b1;
      in_sel   = 3'd1;
      in_data  = 16'h1F1F;
      flush    = 1'b1;
      #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      clear_queues();
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("flush_no_accept", 32'(out_valid), 32'd0);
      chk("flush_keeps_cnt", 32'(drop_cnt), CNT_EN ? 32'd3 : 32'd0);

      // Asynchronous reset with traffic pending
      out_ready = 6'b110111;
      send(3, 16'h3C3C);
      in_valid = 1'b1;
      in_sel   = 3'd0;
      in_data  = 16'h5555;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      clear_queues();
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = '1;
      @(posedge clk); #1;

      // Drop counter saturation
      in_valid = 1'b1;
      in_sel   = 3'd7;
      repeat (65537) @(posedge clk);
      #1;
      chk("sat_drop_cnt", 32'(drop_cnt), CNT_EN ? 32'hFFFF : 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_hold", 32'(drop_cnt), CNT_EN ? 32'hFFFF : 32'd0);
      chk("sat_out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < NOUT; i++)
         chk($sformatf("drain_q%0d", i), 32'(exp_q[i].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
